// File: rtl/fifo_package.sv
// fifo_package: shared FIFO data width plus stream source state type and sizing defaults.
package fifo_package;
  localparam int DATA_WIDTH = 7;
  localparam int LEN_WIDTH = 8;
  localparam int STALL_CNT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, SEND, DONE} stream_src_state_t;
endpackage

// File: rtl/stream_src_datagen.sv
// stream_src_datagen: burst data word register, loaded with base and advanced by a captured step.
module stream_src_datagen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] base,
  input  logic [W-1:0] step,
  output logic [W-1:0] data
);
  logic [W-1:0] step_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      step_q <= '0;
    end else if (load) begin
      data <= base;
      step_q <= step;
    end else if (advance) data <= data + step_q;
endmodule

// File: rtl/fifo_stream_source.sv
// fifo_stream_source: arithmetic-sequence burst source for the FIFO write side.
// Optional STREAM_SRC_STALL_CNT_EN adds a saturating stall_cnt_o.
module fifo_stream_source #(
  parameter int LEN_WIDTH = fifo_package::LEN_WIDTH
`ifdef STREAM_SRC_STALL_CNT_EN
  , parameter int STALL_CNT_WIDTH = fifo_package::STALL_CNT_WIDTH
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [LEN_WIDTH-1:0]              len_i,
  input  logic [fifo_package::DATA_WIDTH:0] base_i,
  input  logic [fifo_package::DATA_WIDTH:0] step_i,
  input  logic                              abort_i,
  output logic                              valid_o,
  output logic [fifo_package::DATA_WIDTH:0] data_o,
  input  logic                              grant_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              aborted_o,
  output logic [LEN_WIDTH-1:0]              sent_cnt_o
`ifdef STREAM_SRC_STALL_CNT_EN
  , output logic [STALL_CNT_WIDTH-1:0]      stall_cnt_o
`endif
);
  import fifo_package::stream_src_state_t;
  import fifo_package::IDLE;
  import fifo_package::SEND;
  import fifo_package::DONE;
  stream_src_state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic abort_pend, launch, xfer, last, abort_now;
  assign launch = state == IDLE && start_i;
  assign xfer = state == SEND && grant_i;
  assign last = sent_cnt_o == len_q - LEN_WIDTH'(1);
  assign abort_now = abort_i || abort_pend;
  // Outputs decode straight from flops so grant_i never reaches them combinationally.
  assign valid_o = state == SEND;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == DONE ? IDLE :
                state == SEND ? (xfer && (last || abort_now) ? DONE : SEND) :
                launch ? (len_i == '0 ? DONE : SEND) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      sent_cnt_o <= '0;
      abort_pend <= 1'b0;
      aborted_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        len_q <= len_i;
        sent_cnt_o <= '0;
        abort_pend <= 1'b0;
        aborted_o <= 1'b0;
      end else if (state == SEND) begin
        abort_pend <= abort_now;
        if (xfer) sent_cnt_o <= sent_cnt_o + LEN_WIDTH'(1);
        // Normal completion on the last word wins over a pending abort.
        if (xfer && !last && abort_now) aborted_o <= 1'b1;
      end
    end
  stream_src_datagen #(.W(fifo_package::DATA_WIDTH + 1)) u_datagen (
    .clk(clk),
    .rst_n(rst_n),
    .load(launch),
    .advance(xfer),
    .base(base_i),
    .step(step_i),
    .data(data_o)
  );
`ifdef STREAM_SRC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt_o <= '0;
    else if (launch) stall_cnt_o <= '0;
    else if (state == SEND && !grant_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STALL_CNT_WIDTH'(1);
`endif
endmodule

// File: tb/tb_fifo_stream_source.sv
// tb_fifo_stream_source: directed and randomized bursts checked against a transaction-level model.
module tb_fifo_stream_source;
  import fifo_package::*;
  localparam int W = DATA_WIDTH + 1;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, grant_i = 1'b0;
  logic [LEN_WIDTH-1:0] len_i = '0;
  logic [W-1:0] base_i = '0, step_i = '0;
  logic valid_o, busy_o, done_o, aborted_o;
  logic [W-1:0] data_o;
  logic [LEN_WIDTH-1:0] sent_cnt_o;
`ifdef STREAM_SRC_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_o;
`endif
  int n_vec = 0, n_err = 0, stalls = 0;
  logic [W-1:0] got_q[$];
  always #5 clk = ~clk;
  fifo_stream_source dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .base_i(base_i),
    .step_i(step_i), .abort_i(abort_i), .valid_o(valid_o), .data_o(data_o),
    .grant_i(grant_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .sent_cnt_o(sent_cnt_o)
`ifdef STREAM_SRC_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: log the handshake seen before the edge, then verify an ungranted word was held.
  task automatic tick();
    logic hold;
    logic [W-1:0] held;
    if (valid_o && grant_i) got_q.push_back(data_o);
    if (valid_o && !grant_i) stalls++;
    hold = valid_o && !grant_i;
    held = data_o;
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_valid", 32'(valid_o), 1);
      check("hold_data", 32'(data_o), 32'(held));
    end
  endtask
  task automatic burst(input int len, input logic [W-1:0] base, input logic [W-1:0] step,
                       input int gmode, input int abort_at, input bit keep);
    int cyc, last_x, xab, m, exp_n;
    bit exp_ab;
    logic [W-1:0] e;
    cyc = 0;
    last_x = -1;
    xab = -1;
    got_q.delete();
    stalls = 0;
    start_i = 1'b1;
    len_i = LEN_WIDTH'(len);
    base_i = base;
    step_i = step;
    grant_i = 1'b1;
    tick();
    start_i = keep;
    while (!done_o && cyc < 300) begin
      abort_i = cyc == abort_at && valid_o;
      if (abort_i && xab < 0) xab = got_q.size();
      grant_i = gmode == 0 ? 1'b1 : gmode == 1 ? 1'(cyc % 2) :
                gmode == 2 ? 1'($urandom_range(0, 1)) : !(cyc >= abort_at && cyc < abort_at + 3);
      m = got_q.size();
      tick();
      if (got_q.size() != m) last_x = cyc;
      cyc++;
    end
    abort_i = 1'b0;
    check("done_seen", 32'(done_o), 1);
    exp_n = (xab < 0 || xab + 1 >= len) ? len : xab + 1;
    exp_ab = xab >= 0 && xab + 1 < len;
    if (len == 0) check("zero_len_lat", 32'(cyc), 0);
    check("done_lat", 32'(last_x), len == 0 ? 32'hffff_ffff : 32'(cyc - 1));
    check("word_count", 32'(got_q.size()), 32'(exp_n));
    e = base;
    foreach (got_q[i]) begin
      check("word", 32'(got_q[i]), 32'(e));
      e = e + step;
    end
    check("sent_cnt", 32'(sent_cnt_o), 32'(exp_n));
    check("aborted", 32'(aborted_o), 32'(exp_ab));
    check("done_valid", 32'(valid_o), 0);
    check("done_busy", 32'(busy_o), 1);
`ifdef STREAM_SRC_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt_o), 32'(stalls));
`endif
    if (!keep) begin
      grant_i = 1'($urandom_range(0, 1));
      tick();
      check("idle_done", 32'(done_o), 0);
      check("idle_busy", 32'(busy_o), 0);
      check("idle_valid", 32'(valid_o), 0);
      check("aborted_sticky", 32'(aborted_o), 32'(exp_ab));
    end
  endtask
  initial begin
    int len, abort_at;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_aborted", 32'(aborted_o), 0);
    check("rst_sent", 32'(sent_cnt_o), 0);
    rst_n = 1'b1;
    tick();
    burst(4, W'(8'hA5), W'(1), 0, -1, 1'b0);
    burst(3, W'(8'hFE), W'(1), 1, -1, 1'b0);
    burst(0, W'(8'h55), W'(1), 2, -1, 1'b0);
    burst(10, W'(8'h3C), W'(4), 3, 2, 1'b0);
    burst(2, W'(8'h10), W'(3), 0, -1, 1'b1);
    grant_i = 1'b1;
    tick();
    check("gap_valid", 32'(valid_o), 0);
    check("gap_busy", 32'(busy_o), 0);
    tick();
    check("restart_valid", 32'(valid_o), 1);
    check("restart_data", 32'(data_o), 32'h10);
    start_i = 1'b0;
    for (int i = 0; i < 10 && !done_o; i++) tick();
    check("restart_done", 32'(done_o), 1);
    check("restart_cnt", 32'(sent_cnt_o), 2);
    tick();
    got_q.delete();
    start_i = 1'b1;
    len_i = LEN_WIDTH'(8);
    base_i = W'(8'h20);
    step_i = W'(2);
    grant_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 5; i++) tick();
    check("pre_rst_words", 32'(got_q.size()), 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 0);
    check("arst_data", 32'(data_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_done", 32'(done_o), 0);
    check("arst_sent", 32'(sent_cnt_o), 0);
    repeat (2) begin
      tick();
      check("rst_no_done", 32'(done_o), 0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 32'(done_o), 0);
    burst(5, W'(8'h77), W'(8'hF0), 2, -1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      len = int'($urandom_range(0, 12));
      abort_at = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 2 * len + 3)) : -1;
      burst(len, W'($urandom), W'($urandom), int'($urandom_range(0, 2)), abort_at, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
